// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in
// system clock cycles, publishing one measurement per period with a one-cycle
// valid strobe and a sticky timeout flag when edges stop arriving.
// Optional glitch filter after the synchronizer: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 20000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);

  if ((FILTER_LEN < 2) || (FILTER_LEN > 16) || (TIMEOUT < 1) ||
      (TIMEOUT > (2 ** WIDTH) - 1)) begin : g_bad_params
    $error("pwm_capture: parameter out of range");
  end

  logic             sync_meta;
  logic             sync_level;
  logic             clean_level;
  logic             prev_level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] high_reg;
  state_t           state;
  state_t           state_next;
  logic             publish;
  logic             latch_high;
  logic             fire_timeout;

  // Two-flop synchronizer bringing the asynchronous input into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= pwm_in;
      sync_level <= sync_meta;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic       filt_level;
  logic [4:0] filt_count;

  // Glitch filter: follow the input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_level <= 1'b0;
      filt_count <= '0;
    end else if (sync_level == filt_level) begin
      filt_count <= '0;
    end else if (filt_count == 5'(FILTER_LEN - 1)) begin
      filt_level <= sync_level;
      filt_count <= '0;
    end else begin
      filt_count <= filt_count + 5'd1;
    end
  end

  assign clean_level = filt_level;
`else
  assign clean_level = sync_level;
`endif

  assign level = clean_level;

  // Registered edge detector: one-cycle rise/fall pulses from the clean level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_level <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      prev_level <= clean_level;
      rise_pulse <= clean_level & ~prev_level;
      fall_pulse <= ~clean_level & prev_level;
    end
  end

  // Measurement counter: restarts at 1 on each rise, saturates instead of wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (rise_pulse) begin
      counter <= WIDTH'(1);
    end else if (counter != CNT_MAX) begin
      counter <= counter + WIDTH'(1);
    end
  end

  // State register for the measurement sequencer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_RISE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: an expected edge always takes priority over the timeout
  always_comb begin
    state_next   = state;
    publish      = 1'b0;
    latch_high   = 1'b0;
    fire_timeout = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (rise_pulse) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (fall_pulse) begin
          latch_high = 1'b1;
          state_next = LOW;
        end else if (counter >= TO_VAL) begin
          fire_timeout = 1'b1;
          state_next   = WAIT_RISE;
        end
      end
      LOW: begin
        if (rise_pulse) begin
          publish    = 1'b1;
          state_next = HIGH;
        end else if (counter >= TO_VAL) begin
          fire_timeout = 1'b1;
          state_next   = WAIT_RISE;
        end
      end
      default: begin
        state_next = WAIT_RISE;
      end
    endcase
  end

  // Hold the high-phase length until the period completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_reg <= '0;
    end else if (latch_high) begin
      high_reg <= counter;
    end
  end

  // Output registers: publish on a completed period, sticky timeout until next valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        period    <= counter;
        high_time <= high_reg;
        timeout   <= 1'b0;
      end else if (fire_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven PWM vectors plus hand-written timeout, reset
// and glitch sequences, checked through a scoreboard of expected measurements.
module tb_pwm_capture;

  localparam int WIDTH      = 16;
  localparam int TIMEOUT    = 20000;
  localparam int FILTER_LEN = 4;

  logic             clock;
  logic             reset;
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             level;

  typedef struct {
    int p;
    int h;
    int n;
    int exp_p;
    int exp_h;
    int exp_valids;
  } vec_t;

  typedef struct {
    int p;
    int h;
  } meas_t;

  meas_t sb[$];
  int    compared    = 0;
  int    mismatched  = 0;
  int    valid_count = 0;

  pwm_capture #(
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT),
    .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pwm_in(pwm_in),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .timeout(timeout),
    .level(level)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pushExpected(input int p, input int h);
    meas_t m;
    m.p = p;
    m.h = h;
    sb.push_back(m);
  endtask

  // One period: high for h cycles then low for l cycles; optionally the rise
  // completes a previous period whose expected measurement is queued
  task automatic drivePeriod(input int h, input int l, input bit push, input int ep, input int eh);
    pwm_in = 1'b1;
    if (push) pushExpected(ep, eh);
    waitCycles(h);
    pwm_in = 1'b0;
    waitCycles(l);
  endtask

  task automatic applyStimulus(input int p, input int h, input int n, input int ep, input int eh,
                               input bit prior);
    for (int i = 0; i < n; i++) begin
      drivePeriod(h, p - h, prior || (i > 0), ep, eh);
    end
  endtask

  task automatic waitDrain(input string name, input int limit);
    int k;
    k = 0;
    while (sb.size() > 0 && k < limit) begin
      @(negedge clock);
      k++;
    end
    checkOutput({name, "_drain"}, sb.size(), 0);
    waitCycles(5);
  endtask

  task automatic doReset();
    pwm_in = 1'b0;
    reset  = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);
  endtask

  // Scoreboard monitor: every valid must match the oldest queued expectation
  always @(negedge clock) begin
    meas_t m;
    if (valid === 1'b1) begin
      valid_count++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid",
                 period, high_time);
      end else begin
        m = sb.pop_front();
        checkOutput("period", int'(period), m.p);
        checkOutput("high_time", int'(high_time), m.h);
        checkOutput("timeout_on_valid", int'(timeout), 0);
      end
    end
  end

  initial begin
    vec_t vecs[5];
    int   start;
    int   hp;
    int   hh;
    bit   filt;

`ifdef PWM_CAPTURE_FILTER_EN
    filt    = 1'b1;
    vecs[0] = '{5000, 1250, 4, 5000, 1250, 3};
    vecs[1] = '{100, 40, 5, 100, 40, 4};
    vecs[2] = '{30, 10, 6, 30, 10, 5};
    vecs[3] = '{16, 8, 5, 16, 8, 4};
    vecs[4] = '{70, 60, 4, 70, 60, 3};
    hp      = 30;
    hh      = 10;
`else
    filt    = 1'b0;
    vecs[0] = '{5000, 1250, 4, 5000, 1250, 3};
    vecs[1] = '{100, 40, 5, 100, 40, 4};
    vecs[2] = '{3, 1, 6, 3, 1, 5};
    vecs[3] = '{2, 1, 5, 2, 1, 4};
    vecs[4] = '{7, 6, 4, 7, 6, 3};
    hp      = 3;
    hh      = 1;
`endif

    // Reset state
    pwm_in = 1'b0;
    reset  = 1'b1;
    waitCycles(3);
    checkOutput("reset_period", int'(period), 0);
    checkOutput("reset_high_time", int'(high_time), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    checkOutput("reset_level", int'(level), 0);
    reset = 1'b0;
    waitCycles(2);

    // Table-driven clean PWM vectors
    for (int i = 0; i < 5; i++) begin
      doReset();
      start = valid_count;
      waitCycles(5);
      applyStimulus(vecs[i].p, vecs[i].h, vecs[i].n, vecs[i].exp_p, vecs[i].exp_h, 1'b0);
      waitDrain($sformatf("vec%0d", i), 100);
      checkOutput($sformatf("vec%0d_valids", i), valid_count - start, vecs[i].exp_valids);
    end

    // Input held low after a short PWM: timeout with level 0
    $display("[TB] hold-low timeout sequence");
    doReset();
    applyStimulus(hp, hh, 4, hp, hh, 1'b0);
    waitDrain("hold_low", 100);
    waitCycles(20030);
    checkOutput("hold_low_timeout", int'(timeout), 1);
    checkOutput("hold_low_level", int'(level), 0);
    checkOutput("hold_low_period_kept", int'(period), hp);
    checkOutput("hold_low_high_kept", int'(high_time), hh);

    // Input held high after a rise: timeout exactly when counter reaches TIMEOUT
    $display("[TB] hold-high timeout sequence");
    doReset();
    applyStimulus(300, 100, 2, 300, 100, 1'b0);
    pwm_in = 1'b1;
    pushExpected(300, 100);
    waitCycles(19990);
    checkOutput("hold_high_no_early_timeout", int'(timeout), 0);
    waitCycles(30);
    checkOutput("hold_high_timeout", int'(timeout), 1);
    checkOutput("hold_high_level", int'(level), 1);
    checkOutput("hold_high_period_kept", int'(period), 300);
    checkOutput("hold_high_high_kept", int'(high_time), 100);
    waitCycles(25000 - 20020);
    pwm_in = 1'b0;
    waitCycles(50);
    start = valid_count;
    applyStimulus(100, 40, 3, 100, 40, 1'b0);
    waitDrain("recover", 100);
    checkOutput("recover_valids", valid_count - start, 2);
    checkOutput("recover_timeout_cleared", int'(timeout), 0);

    // Reset asserted in the middle of a high phase
    $display("[TB] reset mid-high sequence");
    doReset();
    applyStimulus(1000, 500, 2, 1000, 500, 1'b0);
    pwm_in = 1'b1;
    pushExpected(1000, 500);
    waitCycles(250);
    waitDrain("pre_reset", 10);
    reset = 1'b1;
    #1;
    checkOutput("midreset_period", int'(period), 0);
    checkOutput("midreset_high_time", int'(high_time), 0);
    checkOutput("midreset_valid", int'(valid), 0);
    checkOutput("midreset_timeout", int'(timeout), 0);
    checkOutput("midreset_level", int'(level), 0);
    waitCycles(244);
    pwm_in = 1'b0;
    waitCycles(50);
    reset = 1'b0;
    waitCycles(450);
    start = valid_count;
    applyStimulus(1000, 500, 3, 1000, 500, 1'b0);
    waitDrain("post_reset", 100);
    checkOutput("post_reset_valids", valid_count - start, 2);

    // Two-cycle glitch inside the low phase of a 200/50 PWM
    $display("[TB] glitch sequence");
    doReset();
    start = valid_count;
    applyStimulus(200, 50, 2, 200, 50, 1'b0);
    drivePeriod(50, 70, 1'b1, 200, 50);
    drivePeriod(2, 78, !filt, 120, 50);
    drivePeriod(50, 150, 1'b1, filt ? 200 : 80, filt ? 50 : 2);
    drivePeriod(50, 150, 1'b1, 200, 50);
    waitDrain("glitch", 100);
    checkOutput("glitch_valids", valid_count - start, filt ? 4 : 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
